// File: rtl/light_chaser.sv
// light_chaser: single lit LED walking across a WIDTH-bit vector.
// MODE 0 rotates left with wrap, MODE 1 bounces between bit 0 and bit WIDTH-1.
// A prescaler spaces steps STEP_DIV enabled clocks apart. A non-one-hot LED
// vector is repaired to bit 0 on the next clock whatever the enable state.
module light_chaser #(
    parameter int WIDTH    = 8,
    parameter int STEP_DIV = 1,
    parameter int MODE     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] leds
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] LED_HOME = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LED_NONE = {WIDTH{1'b0}};

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] low_cleared;
        low_cleared = v & (v - LED_HOME);
        return (v != LED_NONE) && (low_cleared == LED_NONE);
    endfunction

    logic [WIDTH-1:0] r_leds;
    logic             r_dir_up;
    logic [CNT_W-1:0] r_cnt;

    logic             w_leds_ok;
    logic             w_tick;
    logic             w_go_up;
    logic [WIDTH-1:0] w_next_leds;
    logic             w_next_dir_up;

    // Health of the LED vector and prescaler terminal count.
    always_comb begin
        w_leds_ok = is_one_hot(r_leds);
        w_tick    = (r_cnt == CNT_LAST);
    end

    // Next LED position and direction for one step of the selected pattern.
    always_comb begin
        w_go_up       = 1'b1;
        w_next_leds   = r_leds;
        w_next_dir_up = r_dir_up;
        if (MODE == 1) begin
            // The end bits decide the turn, so a stale direction flag
            // can never push the lit bit off either end.
            if (r_dir_up) begin
                w_go_up = ~r_leds[WIDTH-1];
            end else begin
                w_go_up = r_leds[0];
            end
            if (w_go_up) begin
                w_next_leds   = r_leds << 1;
                w_next_dir_up = 1'b1;
            end else begin
                w_next_leds   = r_leds >> 1;
                w_next_dir_up = 1'b0;
            end
        end else begin
            w_next_leds   = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
            w_next_dir_up = r_dir_up;
        end
    end

    // Position, direction and prescaler state: reset, repair, step or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds   <= LED_HOME;
            r_dir_up <= 1'b1;
            r_cnt    <= CNT_ZERO;
        end else if (!w_leds_ok) begin
            r_leds   <= LED_HOME;
            r_dir_up <= 1'b1;
            r_cnt    <= CNT_ZERO;
        end else if (enable) begin
            if (w_tick) begin
                r_cnt    <= CNT_ZERO;
                r_leds   <= w_next_leds;
                r_dir_up <= w_next_dir_up;
            end else begin
                r_cnt    <= r_cnt + CNT_ONE;
                r_leds   <= r_leds;
                r_dir_up <= r_dir_up;
            end
        end else begin
            r_cnt    <= r_cnt;
            r_leds   <= r_leds;
            r_dir_up <= r_dir_up;
        end
    end

    assign leds = r_leds;

endmodule

// File: tb/tb_light_chaser.sv
// Directed testbench for light_chaser: rotate (default), prescaled rotate
// (STEP_DIV=4) and ping-pong (MODE=1) instances share clock and reset.
module tb_light_chaser;

    logic       clk;
    logic       rst;
    logic       en_rot;
    logic       en_div;
    logic       en_pp;
    logic [7:0] leds_rot;
    logic [7:0] leds_div;
    logic [7:0] leds_pp;

    int total;
    int bad;

    light_chaser u_rot (
        .clk    (clk),
        .rst    (rst),
        .enable (en_rot),
        .leds   (leds_rot)
    );

    light_chaser #(.WIDTH(8), .STEP_DIV(4), .MODE(0)) u_div (
        .clk    (clk),
        .rst    (rst),
        .enable (en_div),
        .leds   (leds_div)
    );

    light_chaser #(.WIDTH(8), .STEP_DIV(1), .MODE(1)) u_pp (
        .clk    (clk),
        .rst    (rst),
        .enable (en_pp),
        .leds   (leds_pp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        en_rot = 1'b0;
        en_div = 1'b0;
        en_pp  = 1'b0;
        for (int i = 0; i < 2; i++) cyc();
        total++;
        if (leds_rot !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_rot got=%b exp=%b", leds_rot, 8'b0000_0001);
        end
        total++;
        if (leds_div !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_div got=%b exp=%b", leds_div, 8'b0000_0001);
        end
        total++;
        if (leds_pp !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_pp got=%b exp=%b", leds_pp, 8'b0000_0001);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if (leds_rot !== 8'b0000_0001) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got=%b exp=%b", i, leds_rot, 8'b0000_0001);
            end
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp;
        en_rot = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            exp = 8'b0000_0001 << (i % 8);
            total++;
            if (leds_rot !== exp) begin
                bad++;
                $display("FAIL rotate step=%0d got=%b exp=%b", i, leds_rot, exp);
            end
            total++;
            if ($countones(leds_rot) != 1) begin
                bad++;
                $display("FAIL rotate_onehot step=%0d got=%b exp=one-hot", i, leds_rot);
            end
        end
        total++;
        if (leds_rot !== 8'b0001_0000) begin
            bad++;
            $display("FAIL rotate_20 got=%b exp=%b", leds_rot, 8'b0001_0000);
        end
    endtask

    task automatic test_freeze_resume();
        logic [7:0] exp;
        en_rot = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if (leds_rot !== 8'b0001_0000) begin
                bad++;
                $display("FAIL freeze cyc=%0d got=%b exp=%b", i, leds_rot, 8'b0001_0000);
            end
        end
        en_rot = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            exp = 8'b0000_0001 << ((20 + i) % 8);
            total++;
            if (leds_rot !== exp) begin
                bad++;
                $display("FAIL resume step=%0d got=%b exp=%b", i, leds_rot, exp);
            end
        end
        total++;
        if (leds_rot !== 8'b0100_0000) begin
            bad++;
            $display("FAIL resume_30 got=%b exp=%b", leds_rot, 8'b0100_0000);
        end
    endtask

    task automatic test_prescaler();
        logic [7:0] exp;
        en_div = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            exp = 8'b0000_0001 << ((k / 4) % 8);
            total++;
            if (leds_div !== exp) begin
                bad++;
                $display("FAIL prescale clk=%0d got=%b exp=%b", k, leds_div, exp);
            end
        end
        // Two enabled clocks into the next period, then a 3-cycle pause.
        for (int k = 0; k < 2; k++) cyc();
        en_div = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++;
            if (leds_div !== 8'b0000_0001) begin
                bad++;
                $display("FAIL prescale_pause cyc=%0d got=%b exp=%b", k, leds_div, 8'b0000_0001);
            end
        end
        en_div = 1'b1;
        cyc();
        total++;
        if (leds_div !== 8'b0000_0001) begin
            bad++;
            $display("FAIL prescale_resume3 got=%b exp=%b", leds_div, 8'b0000_0001);
        end
        cyc();
        total++;
        if (leds_div !== 8'b0000_0010) begin
            bad++;
            $display("FAIL prescale_resume4 got=%b exp=%b", leds_div, 8'b0000_0010);
        end
        en_div = 1'b0;
    endtask

    task automatic test_pingpong();
        logic [7:0] exp;
        int pos;
        en_pp = 1'b1;
        for (int s = 1; s <= 15; s++) begin
            cyc();
            if (s <= 7) pos = s;
            else if (s <= 14) pos = 14 - s;
            else pos = s - 14;
            exp = 8'b0000_0001 << pos;
            total++;
            if (leds_pp !== exp) begin
                bad++;
                $display("FAIL pingpong step=%0d got=%b exp=%b", s, leds_pp, exp);
            end
        end
        en_pp = 1'b0;
    endtask

    task automatic test_reset_mid_and_corrupt();
        // Walk the rotate instance to 00100000 from a fresh reset.
        rst = 1'b1;
        cyc();
        rst    = 1'b0;
        en_rot = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        total++;
        if (leds_rot !== 8'b0010_0000) begin
            bad++;
            $display("FAIL mid_setup got=%b exp=%b", leds_rot, 8'b0010_0000);
        end
        rst = 1'b1;
        cyc();
        total++;
        if (leds_rot !== 8'b0000_0001) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=%b", leds_rot, 8'b0000_0001);
        end
        rst    = 1'b0;
        en_rot = 1'b0;
        cyc();
        force u_rot.r_leds = 8'b0000_0011;
        #1;
        release u_rot.r_leds;
        cyc();
        total++;
        if (leds_rot !== 8'b0000_0001) begin
            bad++;
            $display("FAIL corrupt_repair got=%b exp=%b", leds_rot, 8'b0000_0001);
        end
        // Ping-pong instance: corrupt to all-zero while enabled, repair then walk up.
        en_pp = 1'b1;
        force u_pp.r_leds = 8'b0000_0000;
        #1;
        release u_pp.r_leds;
        cyc();
        total++;
        if (leds_pp !== 8'b0000_0001) begin
            bad++;
            $display("FAIL corrupt_pp_repair got=%b exp=%b", leds_pp, 8'b0000_0001);
        end
        cyc();
        total++;
        if (leds_pp !== 8'b0000_0010) begin
            bad++;
            $display("FAIL corrupt_pp_up got=%b exp=%b", leds_pp, 8'b0000_0010);
        end
        en_pp = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        en_rot = 1'b0;
        en_div = 1'b0;
        en_pp  = 1'b0;
        #1;
        test_reset();
        test_rotate();
        test_freeze_resume();
        test_prescaler();
        test_pingpong();
        test_reset_mid_and_corrupt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_chaser.md
Name: light_chaser

Overview:
- Single-LED "chaser": exactly one bit of an N-bit LED vector is lit, and that bit walks across the vector at a programmable step rate while enabled.
- Leaf peripheral driven from the system clock; output drives board LEDs or status pins directly.
- Supports a circular (rotate-left) pattern and a ping-pong (bounce) pattern, selected by parameter.

Parameters:
- WIDTH, 8, number of LEDs; legal range 2..32.
- STEP_DIV, 1, clock cycles per LED step; legal range 1..2^16. 1 means one step per enabled clock.
- MODE, 0, pattern select: 0 = rotate left with wrap, 1 = ping-pong bounce between bit 0 and bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  advance permission; high lets the pattern move, low freezes it.
- leds  output  WIDTH  one-hot LED vector, registered.

Behaviour:
- Reset (rst=1 at a rising edge):
  - leds = one-hot bit 0 (8'b00000001 at default width).
  - Prescaler count cleared to 0.
  - Direction = up (toward the MSB).
  - Reset overrides enable.
- Prescaler:
  - Counts 0..STEP_DIV-1 on each enabled clock.
  - A step tick occurs on the enabled clock where count == STEP_DIV-1; count then returns to 0.
  - With STEP_DIV=1, every enabled clock is a tick.
  - enable=0: count holds its value and is not cleared.
- Step latency: leds changes on the same rising edge that registers the tick. With STEP_DIV=1, the first change follows the first clock edge sampling enable=1 after reset release.
- MODE 0 (rotate left):
  - leds <= {leds[WIDTH-2:0], leds[WIDTH-1]}.
  - Default width sequence: 00000001 -> 00000010 -> ... -> 10000000 -> 00000001.
  - Period: WIDTH ticks.
- MODE 1 (ping-pong):
  - Moving up: shift left. On reaching bit WIDTH-1, direction flips to down for the next tick.
  - Moving down: shift right. On reaching bit 0, direction flips to up.
  - End bits are lit for one tick each, with no double-dwell.
  - Sequence: 00000001 -> ... -> 10000000 -> 01000000 -> ... -> 00000001 -> 00000010.
  - Period: 2*(WIDTH-1) ticks.
- enable=0: leds, direction and prescaler all hold; output is stable and one-hot. Re-asserting enable resumes from the held position, with no restart and no skipped position.
- One-hot protection: if leds is ever not exactly one-hot (e.g. an SEU), the next clock forces leds to bit 0 and direction to up, regardless of enable.
- Reset asserted mid-sequence: the next edge returns to the reset state. The position before reset is not retained.
- Enable toggling on the same edge as a tick: the enable value sampled at that edge alone decides whether the step occurs.
- leds never changes except on a rising clk edge; no combinational path from any input to leds.

Test Plan:
- Reset: rst=1, enable=0 for 2 cycles -> leds=00000001. Release rst with enable=0 for 5 cycles -> leds stays 00000001.
- Rotate, default parameters: release rst and assert enable for 20 cycles -> leds steps 00000010, 00000100, …, 10000000, 00000001, … once per clock. After 20 steps leds=00010000. Every sample is one-hot.
- Freeze/resume: after 20 enabled steps, drop enable for 5 cycles -> leds holds 00010000. Re-assert enable for 10 cycles -> leds=01000000 (20+10=30 steps; 30 mod 8 = 6).
- Prescaler: STEP_DIV=4, enable held -> leds changes every 4th clock. 32 clocks give exactly 8 steps and leds back at 00000001. Dropping enable for 3 cycles mid-count delays the next step by exactly 3 cycles.
- Ping-pong: MODE=1, WIDTH=8, enable held for 14 cycles -> 7 steps up to 10000000, then 7 steps down back to 00000001. Cycle 15 -> 00000010.
- Reset mid-run plus corruption: assert rst for 1 cycle while leds=00100000 -> next edge leds=00000001. Force leds to 00000011 via bench force/release -> next edge leds=00000001.
